// File: rtl/uart_receiver_defines.sv
// uart_receiver_defines: shared receive-path state encoding and default bit timing
package uart_receiver_defines;
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;
  localparam int CLKS_PER_BIT_DEFAULT = 16;
endpackage

// File: rtl/receiver_baud_counter.sv
// receiver_baud_counter: bit-interval counter with clear, enable and target compare
// Ports: i_clock/i_resetL clock and async active-low reset; i_clear zeroes the count;
// i_enable advances it; o_match is high while the count equals i_target.
module receiver_baud_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clock,
  input  logic             i_resetL,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_target,
  output logic             o_match
);
  logic [WIDTH-1:0] count;
  always_ff @(posedge i_clock or negedge i_resetL)
    if (!i_resetL) count <= '0;
    else if (i_clear) count <= '0;
    else if (i_enable) count <= count + 1'b1;
  assign o_match = count == i_target;
endmodule

// File: rtl/receiver_control_unit.sv
// receiver_control_unit: UART receive control FSM with line synchronizer and bit-centre strobe
// Ports: i_clock/i_resetL clock and async active-low reset; i_rx raw serial line;
// i_equal_MSB last-data-bit flag from the bit counter; o_state_is_* one-hot state;
// o_equal bit-centre strobe; o_sample synchronized line; o_rx_done / o_framing_error
// single-cycle frame result pulses.
module receiver_control_unit
  import uart_receiver_defines::*;
#(
  parameter int CLKS_PER_BIT       = CLKS_PER_BIT_DEFAULT,
  parameter int BAUD_COUNTER_WIDTH = 4
) (
  input  logic i_clock,
  input  logic i_resetL,
  input  logic i_rx,
  input  logic i_equal_MSB,
  output logic o_state_is_IDLE,
  output logic o_state_is_START,
  output logic o_state_is_DATA,
  output logic o_state_is_STOP,
  output logic o_equal,
  output logic o_sample,
  output logic o_rx_done,
  output logic o_framing_error
);
  localparam logic [BAUD_COUNTER_WIDTH-1:0] START_TARGET = BAUD_COUNTER_WIDTH'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_COUNTER_WIDTH-1:0] BIT_TARGET   = BAUD_COUNTER_WIDTH'(CLKS_PER_BIT - 1);
  state_t state;
  logic sync1, sync2, sync_prev, match;
  logic [1:0] arm;
  logic [BAUD_COUNTER_WIDTH-1:0] target;
  assign target = state == START ? START_TARGET : BIT_TARGET;
  assign o_equal = match && state != IDLE;
  assign o_sample = sync2;
  assign o_state_is_IDLE = state == IDLE;
  assign o_state_is_START = state == START;
  assign o_state_is_DATA = state == DATA;
  assign o_state_is_STOP = state == STOP;
  receiver_baud_counter #(.WIDTH(BAUD_COUNTER_WIDTH)) u_baud (
    .i_clock  (i_clock),
    .i_resetL (i_resetL),
    .i_clear  (o_equal || state == IDLE),
    .i_enable (state != IDLE),
    .i_target (target),
    .o_match  (match)
  );
  // sync_prev stays low until sync2 carries a real line sample, so the
  // reset value of the synchronizer never looks like a falling edge.
  always_ff @(posedge i_clock or negedge i_resetL)
    if (!i_resetL) begin
      state <= IDLE;
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync_prev <= 1'b0;
      arm <= 2'b00;
      o_rx_done <= 1'b0;
      o_framing_error <= 1'b0;
    end else begin
      sync1 <= i_rx;
      sync2 <= sync1;
      arm <= {arm[0], 1'b1};
      sync_prev <= sync2 && arm[1];
      o_rx_done <= state == STOP && o_equal && sync2;
      o_framing_error <= state == STOP && o_equal && !sync2;
      case (state)
        IDLE:    state <= sync_prev && !sync2 ? START : IDLE;
        START:   state <= !o_equal ? START : sync2 ? IDLE : DATA;
        DATA:    state <= o_equal && i_equal_MSB ? STOP : DATA;
        STOP:    state <= o_equal ? IDLE : STOP;
        default: state <= IDLE;
      endcase
    end
endmodule
